// File: rtl/intt_result_collector.sv
// rtl/intt_result_collector.sv - INTT multi-lane result capture buffer with in-order drain stream
//
// Collects per-cycle 8-lane result writes from the INTT engine into an
// 8-bank coefficient buffer (bank = index[2:0], row = index[11:3]). After
// io_i_intt_done it streams all 4096 coefficients in index order.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   io_i_intt_we_result     result write strobe (all lanes)
//   io_i_intt_addr_result   packed per-lane row addresses, lane l at [9l+8:9l]
//   io_i_intt_concat        packed per-lane data, lane l at [35l+34:35l]
//   io_i_intt_done          single-cycle frame-complete pulse
//   io_o_out_valid/io_i_out_ready/io_o_out_data/io_o_out_index/io_o_out_last
//                           coefficient output stream, last with index 4095
//   io_o_busy               high while draining
//   io_o_frame_done         one-cycle pulse after the final handshake
//   io_o_wr_count           writes accepted this frame, saturates at 512
//   io_o_short_frame        sticky: done seen with write count != 512
//   io_o_overflow           sticky: write strobe seen while draining
//
// Optional feature macro: INTT_COLLECT_REDUCE_EN
//   defined   - output data is conditionally reduced by MODULUS once
//   undefined - output data is the stored value, bit-exact

module intt_result_collector #(
  parameter int                     COEFF_WIDTH     = 35,
  parameter int                     LANES           = 8,
  parameter int                     LANE_ADDR_WIDTH = 9,
  parameter logic [COEFF_WIDTH-1:0] MODULUS         = 35'h7_FFF0_0001
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      io_i_intt_we_result,
  input  logic [LANES*LANE_ADDR_WIDTH-1:0]          io_i_intt_addr_result,
  input  logic [LANES*COEFF_WIDTH-1:0]              io_i_intt_concat,
  input  logic                                      io_i_intt_done,
  output logic                                      io_o_out_valid,
  input  logic                                      io_i_out_ready,
  output logic [COEFF_WIDTH-1:0]                    io_o_out_data,
  output logic [$clog2(LANES)+LANE_ADDR_WIDTH-1:0]  io_o_out_index,
  output logic                                      io_o_out_last,
  output logic                                      io_o_busy,
  output logic                                      io_o_frame_done,
  output logic [LANE_ADDR_WIDTH:0]                  io_o_wr_count,
  output logic                                      io_o_short_frame,
  output logic                                      io_o_overflow
);

  localparam int BANK_W = $clog2(LANES);
  localparam int IDX_W  = BANK_W + LANE_ADDR_WIDTH;
  localparam int ROWS   = 1 << LANE_ADDR_WIDTH;
  localparam logic [LANE_ADDR_WIDTH:0] FULL_COUNT = (LANE_ADDR_WIDTH+1)'(ROWS);
  localparam logic [IDX_W-1:0]         LAST_IDX   = '1;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  state_t state, state_next;

  logic [COEFF_WIDTH-1:0] mem [LANES][ROWS];

  logic                       wr_en;
  logic                       handshake;
  logic                       drain_end;
  logic                       issue;
  logic [IDX_W:0]             issue_cnt;
  logic [IDX_W-1:0]           issue_idx;
  logic [BANK_W-1:0]          rd_bank;
  logic [LANE_ADDR_WIDTH-1:0] rd_row;
  logic [COEFF_WIDTH-1:0]     rd_raw;
  logic [COEFF_WIDTH-1:0]     rd_coeff;

  // Two-entry output skid: slot[rd_ptr] is the presented coefficient.
  logic [COEFF_WIDTH-1:0]     slot_data [2];
  logic [IDX_W-1:0]           slot_idx  [2];
  logic                       wr_ptr;
  logic                       rd_ptr;
  logic [1:0]                 fill;

  logic [LANE_ADDR_WIDTH:0]   wr_count;
  logic [LANE_ADDR_WIDTH:0]   count_with_write;
  logic                       short_frame;
  logic                       overflow;
  logic                       frame_done;

  assign wr_en = io_i_intt_we_result && (state == COLLECT);

  // Count including a write landing in the same cycle, so a done pulse
  // coincident with the 512th write is not flagged as short.
  assign count_with_write = wr_count +
      {{LANE_ADDR_WIDTH{1'b0}}, (wr_en && (wr_count != FULL_COUNT))};

  assign io_o_out_valid = (fill != 2'd0);
  assign handshake      = io_o_out_valid && io_i_out_ready;
  assign io_o_out_data  = slot_data[rd_ptr];
  assign io_o_out_index = slot_idx[rd_ptr];
  assign io_o_out_last  = io_o_out_valid && (slot_idx[rd_ptr] == LAST_IDX);
  assign drain_end      = (state == DRAIN) && handshake && io_o_out_last;

  // Reads are issued from registered occupancy only: with a one-cycle read
  // into the skid, fill stays at 1 under continuous ready, giving full rate
  // without any ready-to-address combinational path.
  assign issue     = (state == DRAIN) && !issue_cnt[IDX_W] && (fill != 2'd2);
  assign issue_idx = issue_cnt[IDX_W-1:0];
  assign rd_bank   = issue_idx[BANK_W-1:0];
  assign rd_row    = issue_idx[IDX_W-1:BANK_W];
  assign rd_raw    = mem[rd_bank][rd_row];

`ifdef INTT_COLLECT_REDUCE_EN
  assign rd_coeff = (rd_raw >= MODULUS) ? (rd_raw - MODULUS) : rd_raw;
`else
  assign rd_coeff = rd_raw;
`endif

  assign io_o_busy        = (state == DRAIN);
  assign io_o_frame_done  = frame_done;
  assign io_o_wr_count    = wr_count;
  assign io_o_short_frame = short_frame;
  assign io_o_overflow    = overflow;

  // Coefficient buffer: contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        mem[l][io_i_intt_addr_result[l*LANE_ADDR_WIDTH +: LANE_ADDR_WIDTH]]
          <= io_i_intt_concat[l*COEFF_WIDTH +: COEFF_WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (io_i_intt_done) state_next = DRAIN;
      DRAIN:   if (drain_end)      state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_count     <= '0;
      short_frame  <= 1'b0;
      overflow     <= 1'b0;
      frame_done   <= 1'b0;
      issue_cnt    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fill         <= 2'd0;
      slot_data[0] <= '0;
      slot_data[1] <= '0;
      slot_idx[0]  <= '0;
      slot_idx[1]  <= '0;
    end else begin
      frame_done <= drain_end;

      if (drain_end) begin
        wr_count <= '0;
      end else begin
        wr_count <= count_with_write;
      end

      if ((state == COLLECT) && io_i_intt_done && (count_with_write != FULL_COUNT)) begin
        short_frame <= 1'b1;
      end

      if ((state == DRAIN) && io_i_intt_we_result) begin
        overflow <= 1'b1;
      end

      if (state == COLLECT) begin
        issue_cnt <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + (IDX_W+1)'(1);
      end

      if (issue) begin
        slot_data[wr_ptr] <= rd_coeff;
        slot_idx[wr_ptr]  <= issue_idx;
        wr_ptr            <= ~wr_ptr;
      end

      if (handshake) begin
        rd_ptr <= ~rd_ptr;
      end

      fill <= fill + {1'b0, issue} - {1'b0, handshake};
    end
  end

endmodule

// File: tb/tb_intt_result_collector.sv
// tb/tb_intt_result_collector.sv - self-checking bench for intt_result_collector

module tb_intt_result_collector;

  localparam int CW   = 35;
  localparam int L    = 8;
  localparam int AW   = 9;
  localparam int ROWS = 512;
  localparam int N    = 4096;
  localparam logic [CW-1:0] MODV = 35'h7_FFF0_0001;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_i_intt_we_result;
  logic [L*AW-1:0]   io_i_intt_addr_result;
  logic [L*CW-1:0]   io_i_intt_concat;
  logic              io_i_intt_done;
  logic              io_o_out_valid;
  logic              io_i_out_ready;
  logic [CW-1:0]     io_o_out_data;
  logic [11:0]       io_o_out_index;
  logic              io_o_out_last;
  logic              io_o_busy;
  logic              io_o_frame_done;
  logic [9:0]        io_o_wr_count;
  logic              io_o_short_frame;
  logic              io_o_overflow;

  always #5 clock = ~clock;

  intt_result_collector dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_i_intt_we_result   (io_i_intt_we_result),
    .io_i_intt_addr_result (io_i_intt_addr_result),
    .io_i_intt_concat      (io_i_intt_concat),
    .io_i_intt_done        (io_i_intt_done),
    .io_o_out_valid        (io_o_out_valid),
    .io_i_out_ready        (io_i_out_ready),
    .io_o_out_data         (io_o_out_data),
    .io_o_out_index        (io_o_out_index),
    .io_o_out_last         (io_o_out_last),
    .io_o_busy             (io_o_busy),
    .io_o_frame_done       (io_o_frame_done),
    .io_o_wr_count         (io_o_wr_count),
    .io_o_short_frame      (io_o_short_frame),
    .io_o_overflow         (io_o_overflow)
  );

  typedef struct {
    int          n_writes;
    int          stride;
    int          offset;
    logic [CW-1:0] seed;
    bit          ready_rand;
    bit          same_done;
    bit          ovf;
    int          exp_wr_count;
    bit          exp_short;
    bit          exp_ovf;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic [CW-1:0] model [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] expect_out(input logic [CW-1:0] v);
`ifdef INTT_COLLECT_REDUCE_EN
    return (v >= MODV) ? (v - MODV) : v;
`else
    return v;
`endif
  endfunction

  // Lane l of write k targets row (k*stride + l*offset) mod 512 with data
  // {row,lane} ^ seed; the model tracks last-write-wins contents.
  task automatic drive_write(input int k, input int stride, input int offset, input logic [CW-1:0] seed);
    int row;
    logic [CW-1:0] d;
    for (int l = 0; l < L; l++) begin
      row = (k * stride + l * offset) % ROWS;
      d = CW'(row * 8 + l) ^ seed;
      io_i_intt_addr_result[l*AW +: AW] = AW'(row);
      io_i_intt_concat[l*CW +: CW]      = d;
      model[row * 8 + l]                = d;
    end
    io_i_intt_we_result = 1'b1;
  endtask

  task automatic run_frame(input vec_t v, input int abort_idx);
    int exp_idx, bad, stall_bad, bubbles, fd_seen, first_cyc, cyc;
    logic prev_stall, ovf_done, seen_valid;
    logic [CW-1:0] prev_data;
    logic [11:0] prev_idx;

    for (int k = 0; k < v.n_writes; k++) begin
      drive_write(k, v.stride, v.offset, v.seed);
      io_i_intt_done = (v.same_done && (k == v.n_writes - 1));
      @(negedge clock);
      if (k == 0) begin
        check("frame_done_single_cycle", io_o_frame_done, 0);
        check("first_write_counted", io_o_wr_count, 1);
      end
    end
    io_i_intt_we_result = 1'b0;
    if (!v.same_done) begin
      io_i_intt_done = 1'b1;
      @(negedge clock);
    end
    io_i_intt_done = 1'b0;
    check("busy_after_done", io_o_busy, 1);
    check("wr_count_at_done", io_o_wr_count, v.exp_wr_count);

    exp_idx = 0; bad = 0; stall_bad = 0; bubbles = 0; fd_seen = 0;
    first_cyc = 99; cyc = 1;
    prev_stall = 1'b0; ovf_done = 1'b0; seen_valid = 1'b0;
    prev_data = '0; prev_idx = '0;

    while (exp_idx < N && cyc < 20000) begin
      io_i_intt_we_result = 1'b0;
      io_i_intt_done      = 1'b0;
      if (prev_stall && (!io_o_out_valid || io_o_out_data !== prev_data || io_o_out_index !== prev_idx))
        stall_bad++;
      if (io_o_frame_done) fd_seen++;
      if (io_o_out_valid) begin
        if (!seen_valid) begin
          first_cyc  = cyc;
          seen_valid = 1'b1;
        end
        if (io_o_out_data !== expect_out(model[exp_idx]) || io_o_out_index !== 12'(exp_idx) ||
            io_o_out_last !== (exp_idx == N - 1))
          bad++;
        if (abort_idx >= 0 && exp_idx == abort_idx) begin
          reset = 1'b1;
          io_i_out_ready = 1'b1;
          @(negedge clock);
          check("abort_busy", io_o_busy, 0);
          check("abort_valid", io_o_out_valid, 0);
          check("abort_wr_count", io_o_wr_count, 0);
          check("abort_short_cleared", io_o_short_frame, 0);
          check("abort_overflow_cleared", io_o_overflow, 0);
          check("abort_data_before", bad, 0);
          reset = 1'b0;
          io_i_out_ready = 1'b0;
          return;
        end
      end else if (seen_valid && !v.ready_rand) begin
        bubbles++;
      end
      if (v.ovf && !ovf_done && io_o_out_valid && exp_idx == 100) begin
        for (int l = 0; l < L; l++) begin
          io_i_intt_addr_result[l*AW +: AW] = 9'd511;
          io_i_intt_concat[l*CW +: CW]      = 35'h1234;
        end
        io_i_intt_we_result = 1'b1;
        io_i_intt_done      = 1'b1;
        ovf_done            = 1'b1;
      end
      io_i_out_ready = v.ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = io_o_out_valid && !io_i_out_ready;
      prev_data  = io_o_out_data;
      prev_idx   = io_o_out_index;
      if (io_o_out_valid && io_i_out_ready) exp_idx++;
      @(negedge clock);
      cyc++;
    end
    io_i_intt_we_result = 1'b0;
    io_i_intt_done      = 1'b0;
    io_i_out_ready      = 1'b0;

    check("drain_count", exp_idx, N);
    check("drain_data_mismatches", bad, 0);
    check("stall_instability", stall_bad, 0);
    check("bubbles_with_ready", bubbles, 0);
    check("first_valid_within_3", (first_cyc <= 3), 1);
    check("frame_done_early", fd_seen, 0);
    check("frame_done_pulse", io_o_frame_done, 1);
    check("busy_low_at_frame_done", io_o_busy, 0);
    check("valid_low_at_frame_done", io_o_out_valid, 0);
    check("wr_count_cleared", io_o_wr_count, 0);
    check("short_frame_flag", io_o_short_frame, v.exp_short);
    check("overflow_flag", io_o_overflow, v.exp_ovf);
  endtask

  vec_t vecs [7];
  vec_t abort_vec;
  vec_t final_vec;

  initial begin
    //          n    str off seed            rdy  same ovf  wrc  shrt ovf
    vecs[0] = '{512, 1,  0,  35'h0,          1'b0,1'b0,1'b0,512, 1'b0,1'b0};
    vecs[1] = '{512, 1,  0,  35'h5_A5A5_0F0F,1'b0,1'b1,1'b0,512, 1'b0,1'b0};
    vecs[2] = '{520, 1,  0,  35'h7_FFF0_0000,1'b1,1'b0,1'b0,512, 1'b0,1'b0};
    vecs[3] = '{512, 3,  5,  35'h1_2345_6789,1'b1,1'b0,1'b0,512, 1'b0,1'b0};
    vecs[4] = '{100, 1,  0,  35'h3_3333_0000,1'b0,1'b0,1'b0,100, 1'b1,1'b0};
    vecs[5] = '{512, 5,  3,  35'h0_F0F0_F0F0,1'b0,1'b0,1'b0,512, 1'b1,1'b0};
    vecs[6] = '{512, 1,  0,  35'h6_0000_0ABC,1'b0,1'b0,1'b1,512, 1'b1,1'b1};
    abort_vec = '{512, 1, 0, 35'h2_2222_2222, 1'b0,1'b0,1'b0,512, 1'b0,1'b0};
    final_vec = '{512, 9, 17, 35'h4_4444_1111, 1'b1,1'b0,1'b0,512, 1'b0,1'b0};

    reset                 = 1'b1;
    io_i_intt_we_result   = 1'b0;
    io_i_intt_addr_result = '0;
    io_i_intt_concat      = '0;
    io_i_intt_done        = 1'b0;
    io_i_out_ready        = 1'b0;
    repeat (2) @(negedge clock);

    check("reset_out_valid", io_o_out_valid, 0);
    check("reset_out_data", io_o_out_data, 0);
    check("reset_out_index", io_o_out_index, 0);
    check("reset_out_last", io_o_out_last, 0);
    check("reset_busy", io_o_busy, 0);
    check("reset_frame_done", io_o_frame_done, 0);
    check("reset_wr_count", io_o_wr_count, 0);
    check("reset_short_frame", io_o_short_frame, 0);
    check("reset_overflow", io_o_overflow, 0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], -1);
    end

    // Vector 2's seed makes index 6 hold MODULUS+5.
    check("row511_last_write_data", model[4095], 35'h6_0000_0ABC ^ 35'(4095));

    run_frame(abort_vec, 2000);
    run_frame(final_vec, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
